sysid_verify_ctrl: RTL
======================

// Module: sysid_verify_ctrl
// PURPOSE
//  Avalon-MM read master that checks the system-ID slave at boot or on demand.
//  Reads word 0 (ID) and optionally word 1 (timestamp), then compares both against expected values.
//  Retries on bus timeout and reports pass/fail status to the HPS/debug logic.
//  Sits between reset/boot sequencing and the sysid control slave on the interconnect.
// PARAMETERS
//  EXPECTED_ID     32'h0000_0000  expected value at address 0
//  EXPECTED_TS     32'd1455737899 expected value at address 1
//  CHECK_TS        1              1: read/compare address 1; 0: ID only
//  TIMEOUT_CYCLES  256            max cycles per read transaction (accept + data), >=2
//  MAX_RETRIES     3              retry attempts after the first timeout, 0..3
// PORTS
//  clock             in   1   system clock
//  reset_n           in   1   asynchronous active-low reset
//  start             in   1   begin a check; sampled only in IDLE
//  avm_address       out  1   0=ID, 1=timestamp
//  avm_read          out  1   read request, held until !avm_waitrequest
//  avm_waitrequest   in   1   slave stall
//  avm_readdata      in   32  read data, valid with avm_readdatavalid
//  avm_readdatavalid in   1   read data strobe
//  busy              out  1   high in every state except IDLE
//  done              out  1   one-cycle pulse when the result is final
//  pass              out  1   sticky: last check matched, no timeout
//  id_mismatch       out  1   sticky: ID differed
//  ts_mismatch       out  1   sticky: timestamp differed (0 if CHECK_TS=0)
//  timeout           out  1   sticky: retries exhausted
//  retry_count       out  2   retries used in the last check
//  captured_id       out  32  last ID read
//  captured_ts       out  32  last timestamp read
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0; takes effect immediately, including mid-transaction.
//  FSM states: IDLE, RD_ID, WT_ID, RD_TS, WT_TS, BACKOFF, CHECK, FIN.
//  IDLE: if start, clear the sticky flags and retry_count, then go to RD_ID; start outside IDLE is ignored.
//  RD_x: avm_read=1, avm_address=x.
//   - Request accepted (avm_read & !avm_waitrequest): go to WT_x.
//  WT_x: avm_read=0.
//   - avm_readdatavalid: capture avm_readdata into captured_x.
//   - Next state: WT_ID -> RD_TS if CHECK_TS, else CHECK; WT_TS -> CHECK.
//   - avm_readdatavalid is ignored in every other state (no same-cycle-as-accept data).
//  Timeout counter: cleared on entry to RD_x; increments each cycle in RD_x/WT_x.
//   - Reaching TIMEOUT_CYCLES-1 without data: drop avm_read.
//   - If retry_count < MAX_RETRIES: retry_count++, then BACKOFF.
//   - Otherwise: timeout=1, then FIN.
//   - A timeout and data arriving in the same cycle: data wins.
//  BACKOFF: waits TIMEOUT_CYCLES cycles, discarding stray readdatavalid, then RD_ID (full restart).
//  CHECK: set id_mismatch and ts_mismatch from the compares.
//   - pass = no mismatch; a mismatch is final and is not retried. Then FIN.
//  FIN: done=1 for one cycle, then IDLE.
//  Zero-wait latency, start sampled at cycle N:
//   - CHECK_TS=1: done at N+6.
//   - CHECK_TS=0: done at N+4.
//  Never more than one outstanding read.
// TESTING
//  Zero-wait slave returns 0 / 1455737899, start pulse -> done at N+6, pass=1, flags 0, retry_count=0.
//  Slave returns ID 32'h1 -> done, pass=0, id_mismatch=1, captured_id=1, no retry.
//  waitrequest high for 5 cycles on each read -> done at N+16, pass=1, no timeout.
//  Slave never asserts readdatavalid, MAX_RETRIES=3 -> 4 attempts, timeout=1, retry_count=3, pass=0.
//  reset_n low while in WT_TS -> all outputs 0 immediately; next start passes normally.
//  start pulsed again while busy -> ignored; exactly one done pulse.

Source files
------------

// File: rtl/sysid_verify_ctrl.sv
// Boot-time system-ID checker: Avalon-MM read master that fetches the ID and
// (optionally) timestamp words, retries on bus timeout and reports the verdict.
module sysid_verify_ctrl #(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'd1455737899,
  parameter bit          CHECK_TS       = 1'b1,
  parameter int          TIMEOUT_CYCLES = 256,
  parameter int          MAX_RETRIES    = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timeout,
  output logic [1:0]  retry_count,
  output logic [31:0] captured_id,
  output logic [31:0] captured_ts
);

  localparam int            CW        = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]    RETRY_MAX = 2'(MAX_RETRIES);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ID   = 3'd1,
    WT_ID   = 3'd2,
    RD_TS   = 3'd3,
    WT_TS   = 3'd4,
    BACKOFF = 3'd5,
    CHECK   = 3'd6,
    FIN     = 3'd7
  } state_t;

  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic          cnt_expired_s;
  logic          retry_ok_s;

  function automatic logic word_differs(input logic [31:0] a, input logic [31:0] b);
    return (a != b);
  endfunction

  // One counter serves both the per-transaction timeout and the backoff wait.
  assign cnt_expired_s = (cnt_r == CNT_LAST);
  assign retry_ok_s    = (retry_count < RETRY_MAX);

  // Sequencer with all outputs registered; done defaults low so it pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      avm_address <= 1'b0;
      avm_read    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      id_mismatch <= 1'b0;
      ts_mismatch <= 1'b0;
      timeout     <= 1'b0;
      retry_count <= 2'd0;
      captured_id <= 32'd0;
      captured_ts <= 32'd0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            pass        <= 1'b0;
            id_mismatch <= 1'b0;
            ts_mismatch <= 1'b0;
            timeout     <= 1'b0;
            retry_count <= 2'd0;
            busy        <= 1'b1;
            avm_read    <= 1'b1;
            avm_address <= 1'b0;
            cnt_r       <= '0;
            state_r     <= RD_ID;
          end
        end
        RD_ID, RD_TS: begin
          if (cnt_expired_s) begin
            avm_read <= 1'b0;
            if (retry_ok_s) begin
              retry_count <= retry_count + 2'd1;
              cnt_r       <= '0;
              state_r     <= BACKOFF;
            end else begin
              timeout <= 1'b1;
              state_r <= FIN;
            end
          end else if (!avm_waitrequest) begin
            avm_read <= 1'b0;
            cnt_r    <= cnt_r + 1'b1;
            state_r  <= (state_r == RD_ID) ? WT_ID : WT_TS;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        WT_ID, WT_TS: begin
          // Data arriving on the expiry cycle still counts as a good read.
          if (avm_readdatavalid) begin
            if (state_r == WT_ID) begin
              captured_id <= avm_readdata;
              if (CHECK_TS) begin
                avm_read    <= 1'b1;
                avm_address <= 1'b1;
                cnt_r       <= '0;
                state_r     <= RD_TS;
              end else begin
                state_r <= CHECK;
              end
            end else begin
              captured_ts <= avm_readdata;
              state_r     <= CHECK;
            end
          end else if (cnt_expired_s) begin
            if (retry_ok_s) begin
              retry_count <= retry_count + 2'd1;
              cnt_r       <= '0;
              state_r     <= BACKOFF;
            end else begin
              timeout <= 1'b1;
              state_r <= FIN;
            end
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        BACKOFF: begin
          // A retry always restarts from the ID word.
          if (cnt_expired_s) begin
            avm_read    <= 1'b1;
            avm_address <= 1'b0;
            cnt_r       <= '0;
            state_r     <= RD_ID;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        CHECK: begin
          id_mismatch <= word_differs(captured_id, EXPECTED_ID);
          ts_mismatch <= CHECK_TS && word_differs(captured_ts, EXPECTED_TS);
          pass        <= !word_differs(captured_id, EXPECTED_ID) &&
                         !(CHECK_TS && word_differs(captured_ts, EXPECTED_TS));
          state_r     <= FIN;
        end
        FIN: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          avm_read <= 1'b0;
          busy     <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

endmodule
